// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the multi-channel MAC.
package mac_pkg;

    typedef enum logic [1:0] {
        OP_MAC  = 2'b00,
        OP_LOAD = 2'b01,
        OP_DUMP = 2'b10
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MULT,
        ST_ACCUM,
        ST_OUT
    } state_e;

    function automatic int acc_width(input int data_width, input int guard_bits);
        return 2 * data_width + guard_bits;
    endfunction

    function automatic int ch_width(input int num_ch);
        return $clog2(num_ch);
    endfunction

endpackage

// File: rtl/booth_iter_core.sv
// Radix-2 Booth multiplier, one multiplier bit per cycle. done is high during the
// final iteration; product is valid from the following cycle until the next start.
module booth_iter_core #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic signed [DATA_WIDTH-1:0]   a,
    input  logic signed [DATA_WIDTH-1:0]   b,
    output logic                           done,
    output logic signed [2*DATA_WIDTH-1:0] product
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(W + 1);

    // One extra high bit so subtracting the most negative multiplicand cannot overflow.
    logic signed [W:0]   acc_hi;
    logic signed [W:0]   mcand;
    logic signed [W:0]   sum_c;
    logic        [W-1:0] mplier;
    logic                q_m1;
    logic                busy;
    logic [CNT_W-1:0]    cnt;

    always_comb begin
        sum_c = acc_hi;
        case ({mplier[0], q_m1})
            2'b01:   sum_c = acc_hi + mcand;
            2'b10:   sum_c = acc_hi - mcand;
            default: sum_c = acc_hi;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CNT_W'(W);
        end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1))
                busy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            acc_hi <= '0;
            mcand  <= {a[W-1], a};
            mplier <= b;
            q_m1   <= 1'b0;
        end else if (busy) begin
            acc_hi <= {sum_c[W], sum_c[W:1]};
            mplier <= {sum_c[0], mplier[W-1:1]};
            q_m1   <= mplier[0];
        end
    end

    assign done    = busy && (cnt == CNT_W'(1));
    assign product = {acc_hi[W-1:0], mplier};

endmodule

// File: rtl/multi_channel_mac.sv
// Multi-channel multiply-accumulate: one command at a time through an iterative
// Booth multiplier into a bank of per-channel accumulators with sticky overflow flags.
module multi_channel_mac
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int GUARD_BITS  = 8,
    parameter int NUM_CH      = 4,
    parameter int SAT_EN      = 1,
    localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, GUARD_BITS),
    localparam int CH_W       = ch_width(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_all,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_op,
    input  logic [CH_W-1:0]              in_ch,
    input  logic signed [DATA_WIDTH-1:0] in_a,
    input  logic signed [DATA_WIDTH-1:0] in_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_WIDTH-1:0]         out_data,
    output logic [CH_W-1:0]              out_ch,
    output logic                         out_sat
);
    state_e state, state_nxt;

    logic                          load_q;
    logic [CH_W-1:0]               ch_q;
    logic signed [ACC_WIDTH-1:0]   acc [NUM_CH];
    logic [NUM_CH-1:0]             sat;
    logic                          in_fire, out_fire, is_dump;
    logic                          mul_start, mul_done;
    logic signed [2*DATA_WIDTH-1:0] mul_prod;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic [ACC_WIDTH:0]            mac_res;

    // Returns {overflow, result}; the result clamps only when SAT_EN is set.
    function automatic logic [ACC_WIDTH:0] sat_add(input logic signed [ACC_WIDTH-1:0] x,
                                                   input logic signed [ACC_WIDTH-1:0] y);
        logic signed [ACC_WIDTH-1:0] s;
        logic                        ovf;
        s   = x + y;
        ovf = (x[ACC_WIDTH-1] == y[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != x[ACC_WIDTH-1]);
        if (ovf && SAT_EN != 0)
            s = x[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        return {ovf, s};
    endfunction

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_OUT);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign is_dump   = (in_op == OP_DUMP);
    assign mul_start = in_fire && !is_dump;
    assign prod_ext  = ACC_WIDTH'(mul_prod);
    assign mac_res   = sat_add(acc[ch_q], prod_ext);

    booth_iter_core #(.DATA_WIDTH(DATA_WIDTH)) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (in_a),
        .b       (in_b),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (in_fire) state_nxt = is_dump ? ST_OUT : ST_MULT;
            ST_MULT:  if (mul_done) state_nxt = ST_ACCUM;
            ST_ACCUM: state_nxt = ST_IDLE;
            ST_OUT:   if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            load_q <= 1'b0;
            ch_q   <= '0;
        end else begin
            state <= state_nxt;
            if (in_fire) begin
                load_q <= (in_op == OP_LOAD);
                ch_q   <= in_ch;
            end
        end
    end

    // clr_all outranks the ACCUM write and the post-dump clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
            sat <= '0;
        end else if (clr_all) begin
            for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
            sat <= '0;
        end else if (state == ST_ACCUM) begin
            if (load_q) begin
                acc[ch_q] <= prod_ext;
                sat[ch_q] <= 1'b0;
            end else begin
                acc[ch_q] <= mac_res[ACC_WIDTH-1:0];
                sat[ch_q] <= sat[ch_q] | mac_res[ACC_WIDTH];
            end
        end else if (out_fire) begin
            acc[out_ch] <= '0;
            sat[out_ch] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_ch   <= '0;
            out_sat  <= 1'b0;
        end else if (in_fire && is_dump) begin
            out_data <= acc[in_ch];
            out_ch   <= in_ch;
            out_sat  <= sat[in_ch];
        end
    end

endmodule

// File: tb/tb_multi_channel_mac.sv
// Bench for multi_channel_mac: three configurations share one stimulus stream and
// are checked every cycle against a command-level accumulator model.
module tb_multi_channel_mac;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n, clr_all, in_valid, out_ready;
    logic [1:0] in_op;
    logic [1:0] in_ch;
    logic signed [DW-1:0] in_a, in_b;

    logic rdy0, rdy1, rdy2, ov0, ov1, ov2, os0, os1, os2;
    logic [1:0] oc0, oc1, oc2;
    logic signed [39:0] od0;
    logic signed [31:0] od1, od2;

    int checks = 0;
    int failures = 0;

    // Model: configs 0 (40-bit, sat), 1 (32-bit, sat), 2 (32-bit, wrap)
    int     accw [3]  = '{40, 32, 32};
    bit     saten [3] = '{1'b1, 1'b1, 1'b0};
    longint m_acc [3][4];
    bit     m_sat [3][4];
    bit     exp_valid = 1'b0;
    int     exp_ch = 0;
    longint exp_data [3];
    bit     exp_sat [3];
    longint g_d [3];
    bit     g_s [3];
    int     g_ch;
    int     lat;

    always #5 clk = ~clk;

    multi_channel_mac dut0 (
        .clk(clk), .rst_n(rst_n), .clr_all(clr_all), .in_valid(in_valid), .in_ready(rdy0),
        .in_op(in_op), .in_ch(in_ch), .in_a(in_a), .in_b(in_b), .out_valid(ov0),
        .out_ready(out_ready), .out_data(od0), .out_ch(oc0), .out_sat(os0));

    multi_channel_mac #(.GUARD_BITS(0), .SAT_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr_all(clr_all), .in_valid(in_valid), .in_ready(rdy1),
        .in_op(in_op), .in_ch(in_ch), .in_a(in_a), .in_b(in_b), .out_valid(ov1),
        .out_ready(out_ready), .out_data(od1), .out_ch(oc1), .out_sat(os1));

    multi_channel_mac #(.GUARD_BITS(0), .SAT_EN(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr_all(clr_all), .in_valid(in_valid), .in_ready(rdy2),
        .in_op(in_op), .in_ch(in_ch), .in_a(in_a), .in_b(in_b), .out_valid(ov2),
        .out_ready(out_ready), .out_data(od2), .out_ch(oc2), .out_sat(os2));

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic void model_clear();
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 4; i++) begin
                m_acc[c][i] = 0;
                m_sat[c][i] = 1'b0;
            end
    endfunction

    function automatic void model_op(input int c, input int ch, input bit load, input longint prod);
        longint mx, mn, s;
        mx = (64'sd1 <<< (accw[c] - 1)) - 1;
        mn = -mx - 1;
        if (load) begin
            m_acc[c][ch] = prod;
            m_sat[c][ch] = 1'b0;
        end else begin
            s = m_acc[c][ch] + prod;
            if (s > mx || s < mn) begin
                m_sat[c][ch] = 1'b1;
                if (saten[c]) s = (s > mx) ? mx : mn;
                else          s = (s > mx) ? s - (64'sd1 <<< accw[c]) : s + (64'sd1 <<< accw[c]);
            end
            m_acc[c][ch] = s;
        end
    endfunction

    // Per-cycle comparison of all three DUTs against the model
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("out_valid0", ov0, exp_valid);
            chk("out_valid1", ov1, exp_valid);
            chk("out_valid2", ov2, exp_valid);
            if (exp_valid) begin
                chk("out_data0", od0, exp_data[0]);
                chk("out_data1", od1, exp_data[1]);
                chk("out_data2", od2, exp_data[2]);
                chk("out_sat0", os0, exp_sat[0]);
                chk("out_sat1", os1, exp_sat[1]);
                chk("out_sat2", os2, exp_sat[2]);
                chk("out_ch0", oc0, exp_ch);
                chk("out_ch2", oc2, exp_ch);
            end
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rdy0 === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wait_in_ready actual=0 required=1");
        end
    endtask

    // clr_k / rst_k: cycle index after the handshake in which clr_all / rst_n is applied (-1 = none)
    task automatic cmd(input logic [1:0] op, input int ch, input int a, input int b,
                       input int clr_k, input int rst_k, output int l);
        bit ok;
        longint prod;
        l = -1;
        wait_ready(ok);
        if (!ok) return;
        in_valid = 1'b1; in_op = op; in_ch = 2'(ch); in_a = DW'(a); in_b = DW'(b);
        @(posedge clk);
        #1 in_valid = 1'b0;
        prod = longint'(a) * longint'(b);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            clr_all = (k == clr_k);
            if (k == clr_k) model_clear();
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1 chk("ready_in_reset", rdy0, 1);
                model_clear();
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                #1 chk("ready_after_reset", rdy0, 1);
                l = 0;
                return;
            end
            if (rdy0 === 1'b1) begin
                l = k;
                break;
            end
        end
        clr_all = 1'b0;
        if (l < 0) begin
            checks++;
            failures++;
            $display("FAIL cmd_complete actual=busy required=ready");
        end else if (clr_k != DW + 1) begin
            for (int c = 0; c < 3; c++) model_op(c, ch, op == 2'b01, prod);
        end
    endtask

    task automatic dump(input int ch, input int hold, input int clr_k);
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        in_valid = 1'b1; in_op = 2'b10; in_ch = 2'(ch);
        in_a = DW'($urandom); in_b = DW'($urandom);
        out_ready = (hold == 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        exp_valid = 1'b1;
        exp_ch = ch;
        for (int c = 0; c < 3; c++) begin
            exp_data[c] = m_acc[c][ch];
            exp_sat[c]  = m_sat[c][ch];
        end
        g_d[0] = longint'(od0); g_d[1] = longint'(od1); g_d[2] = longint'(od2);
        g_s[0] = os0; g_s[1] = os1; g_s[2] = os2;
        g_ch = int'(oc0);
        for (int k = 1; k <= hold + 1; k++) begin
            @(negedge clk);
            clr_all = (k == clr_k);
            if (k == clr_k) model_clear();
            out_ready = (k == hold + 1);
        end
        @(posedge clk);
        #1 clr_all = 1'b0;
        exp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            m_acc[c][ch] = 0;
            m_sat[c][ch] = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; clr_all = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 2'b00; in_ch = 2'd0; in_a = '0; in_b = '0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_in_ready", rdy0, 1);
        chk("rst_in_ready1", rdy1, 1);
        chk("rst_out_valid", ov0, 0);
        chk("rst_out_data", od0, 0);
        chk("rst_out_data2", od2, 0);
        chk("rst_out_ch", oc0, 0);
        chk("rst_out_sat", os0, 0);
        rst_n = 1'b1;

        // MAC ch1 3*-5, then dump; in_ready returns in cycle 18
        cmd(2'b00, 1, 3, -5, -1, -1, lat);
        chk("ready_latency", lat, DW + 2);
        dump(1, 0, -1);
        chk("lit_mac_neg", g_d[0], -15);
        chk("lit_mac_ch", g_ch, 1);
        chk("lit_mac_sat", g_s[0], 0);

        // Interleaved channels
        cmd(2'b00, 0, 100, 200, -1, -1, lat);
        cmd(2'b00, 2, -7, 7, -1, -1, lat);
        cmd(2'b00, 0, 100, 200, -1, -1, lat);
        cmd(2'b00, 2, -7, 7, -1, -1, lat);
        dump(0, 0, -1);
        chk("lit_ch0", g_d[0], 40000);
        dump(2, 0, -1);
        chk("lit_ch2", g_d[0], -98);
        dump(1, 0, -1);
        chk("lit_ch1_idle", g_d[0], 0);
        dump(3, 0, -1);
        chk("lit_ch3_idle", g_d[2], 0);

        // Overflow without guard bits: saturate vs wrap
        cmd(2'b01, 0, -32768, -32768, -1, -1, lat);
        cmd(2'b00, 0, -32768, -32768, -1, -1, lat);
        dump(0, 0, -1);
        chk("lit_sat_data", g_d[1], 64'sh7FFFFFFF);
        chk("lit_sat_flag", g_s[1], 1);
        chk("lit_wrap_data", g_d[2], -64'sd2147483648);
        chk("lit_wrap_flag", g_s[2], 1);
        chk("lit_guard_data", g_d[0], 64'sd2147483648);
        chk("lit_guard_flag", g_s[0], 0);

        // LOAD after an overflow clears the sticky flag
        cmd(2'b01, 0, -32768, -32768, -1, -1, lat);
        cmd(2'b00, 0, -32768, -32768, -1, -1, lat);
        cmd(2'b01, 0, 2, 3, -1, -1, lat);
        dump(0, 0, -1);
        chk("lit_load_clr_sat", g_s[1], 0);
        chk("lit_load_data", g_d[1], 6);

        // Held dump with clr_all pulse inside the hold
        cmd(2'b01, 2, 12, -11, -1, -1, lat);
        cmd(2'b01, 3, 7, 7, -1, -1, lat);
        dump(2, 5, 3);
        chk("lit_held_dump", g_d[0], -132);
        dump(2, 0, -1);
        chk("lit_after_dump", g_d[0], 0);
        dump(3, 0, -1);
        chk("lit_clr_other_ch", g_d[0], 0);

        // clr_all in the ACCUM cycle drops the write
        cmd(2'b01, 3, 5, 5, -1, -1, lat);
        cmd(2'b00, 3, 2, 2, DW + 1, -1, lat);
        dump(3, 0, -1);
        chk("lit_clr_accum", g_d[0], 0);

        // clr_all mid-MULT still lands the write on the cleared channel
        cmd(2'b01, 1, 10, 10, -1, -1, lat);
        cmd(2'b00, 1, 3, 4, 5, -1, lat);
        dump(1, 0, -1);
        chk("lit_clr_mult", g_d[0], 12);

        // Opcode 11 acts as MAC
        cmd(2'b01, 3, -32768, 32767, -1, -1, lat);
        cmd(2'b11, 3, 1, 1, -1, -1, lat);
        dump(3, 0, -1);
        chk("lit_op11", g_d[0], -1073709055);

        // Reset mid-MULT abandons the LOAD
        cmd(2'b01, 1, 4, 4, -1, -1, lat);
        cmd(2'b01, 1, 9, 9, -1, 6, lat);
        dump(1, 0, -1);
        chk("lit_rst_mult", g_d[0], 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
